// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder: device side of the SPI/QSPI memory bus, backed by a byte
// array. The bus is oversampled with clk; sclk rise samples inputs, sclk fall
// updates outputs. A backdoor port allows preload and readback.
module qspi_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int QUAD_DUMMY  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs_n,
    input  logic                     sclk,
    input  logic [3:0]               io_in,
    output logic [3:0]               io_out,
    output logic [3:0]               io_oe,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  logic [7:0]               bd_wdata,
    output logic [7:0]               bd_rdata,
    output logic                     cmd_err
);
    // state   | meaning
    // IDLE    | waiting for a cs_n falling edge
    // CMD     | shifting in the 8-bit opcode on io[0]
    // ADDR    | shifting in the 24-bit address (single-bit or nibble-wide)
    // DUMMY   | quad read wait cycles before the first data nibble
    // RD_DATA | driving memory bytes out, index auto-increments
    // WR_DATA | assembling bytes from the bus, index auto-increments
    // IGNORE  | unsupported opcode, idle until cs_n rises

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 6;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_OP    = CW'(8);
    localparam logic [CW-1:0] CNT_ASGL  = CW'(24);
    localparam logic [CW-1:0] CNT_AQUAD = CW'(6);
    localparam logic [CW-1:0] CNT_DUMMY = CW'(QUAD_DUMMY);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;

    logic [7:0] mem [DEPTH];

    logic [SYNC_STAGES-1:0] cs_ff, sclk_ff;
    logic [3:0]             io_ff [SYNC_STAGES];
    logic                   cs_s, sclk_s, cs_d, sclk_d;
    logic [3:0]             io_s;
    logic                   rise, fall, cs_fall;

    state_t        state;
    logic          op_rd, op_quad;
    logic [CW-1:0] cnt, cnt_data;
    logic [6:0]    cmd_sh, wr_sh;
    logic [AW-2:0] addr_sh;
    logic [AW-1:0] idx, idx_nx, wr_idx, addr_nx;
    logic [7:0]    rd_sh, cmd_nx, wr_nx, wr_data;
    logic          wr_pend;

    assign cs_s    = cs_ff[SYNC_STAGES-1];
    assign sclk_s  = sclk_ff[SYNC_STAGES-1];
    assign io_s    = io_ff[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign cs_fall = cs_d & ~cs_s;

    assign cmd_nx   = {cmd_sh, io_s[0]};
    assign addr_nx  = op_quad ? {addr_sh[AW-5:0], io_s} : {addr_sh, io_s[0]};
    assign wr_nx    = op_quad ? {wr_sh[3:0], io_s} : {wr_sh, io_s[0]};
    assign idx_nx   = idx + AW'(1);
    assign cnt_data = op_quad ? CW'(2) : CW'(8);

    // Synchronise the bus and keep delayed copies for edge detection. cs resets
    // low so a frame already active at reset release never shows a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_ff   <= '0;
            sclk_ff <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) io_ff[i] <= '0;
            cs_d    <= 1'b0;
            sclk_d  <= 1'b0;
        end else begin
            cs_ff[0]   <= cs_n;
            sclk_ff[0] <= sclk;
            io_ff[0]   <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_ff[i]   <= cs_ff[i-1];
                sclk_ff[i] <= sclk_ff[i-1];
                io_ff[i]   <= io_ff[i-1];
            end
            cs_d   <= cs_s;
            sclk_d <= sclk_s;
        end
    end

    // Protocol FSM with registered bus outputs and the bus write request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_rd   <= 1'b0;
            op_quad <= 1'b0;
            cnt     <= '0;
            cmd_sh  <= '0;
            addr_sh <= '0;
            wr_sh   <= '0;
            idx     <= '0;
            rd_sh   <= '0;
            wr_data <= '0;
            wr_idx  <= '0;
            wr_pend <= 1'b0;
            io_out  <= '0;
            io_oe   <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            // A backdoor write wins the port; the pending bus write simply waits.
            if (wr_pend && !bd_we) wr_pend <= 1'b0;
            if (cs_s) begin
                state  <= IDLE;
                cnt    <= '0;
                io_out <= '0;
                io_oe  <= '0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state <= CMD;
                        cnt   <= CNT_OP;
                    end
                    CMD: if (rise) begin
                        cmd_sh <= cmd_nx[6:0];
                        if (cnt == CNT_ONE) begin
                            case (cmd_nx)
                                8'h03: begin state <= ADDR; op_rd <= 1'b1; op_quad <= 1'b0; cnt <= CNT_ASGL; end
                                8'h02: begin state <= ADDR; op_rd <= 1'b0; op_quad <= 1'b0; cnt <= CNT_ASGL; end
                                8'hEB: begin state <= ADDR; op_rd <= 1'b1; op_quad <= 1'b1; cnt <= CNT_AQUAD; end
                                8'h38: begin state <= ADDR; op_rd <= 1'b0; op_quad <= 1'b1; cnt <= CNT_AQUAD; end
                                default: begin state <= IGNORE; cmd_err <= 1'b1; end
                            endcase
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    ADDR: if (rise) begin
                        addr_sh <= addr_nx[AW-2:0];
                        if (cnt == CNT_ONE) begin
                            idx <= addr_nx;
                            if (op_rd && op_quad && QUAD_DUMMY > 0) begin
                                state <= DUMMY;
                                cnt   <= CNT_DUMMY;
                            end else if (op_rd) begin
                                state <= RD_DATA;
                                rd_sh <= mem[addr_nx];
                                cnt   <= cnt_data;
                            end else begin
                                state <= WR_DATA;
                                cnt   <= cnt_data;
                            end
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    DUMMY: if (rise) begin
                        if (cnt == CNT_ONE) begin
                            state <= RD_DATA;
                            rd_sh <= mem[idx];
                            cnt   <= cnt_data;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    RD_DATA: if (fall) begin
                        io_oe  <= op_quad ? 4'b1111 : 4'b0010;
                        io_out <= op_quad ? rd_sh[7:4] : {2'b00, rd_sh[7], 1'b0};
                        if (cnt == CNT_ONE) begin
                            idx   <= idx_nx;
                            rd_sh <= mem[idx_nx];
                            cnt   <= cnt_data;
                        end else begin
                            rd_sh <= op_quad ? {rd_sh[3:0], 4'b0000} : {rd_sh[6:0], 1'b0};
                            cnt   <= cnt - CNT_ONE;
                        end
                    end
                    WR_DATA: if (rise) begin
                        wr_sh <= wr_nx[6:0];
                        if (cnt == CNT_ONE) begin
                            wr_data <= wr_nx;
                            wr_idx  <= idx;
                            wr_pend <= 1'b1;
                            idx     <= idx_nx;
                            cnt     <= cnt_data;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    IGNORE: io_oe <= '0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Single write port shared between the backdoor and the bus.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        else if (wr_pend) mem[wr_idx] <= wr_data;
    end

    // Registered backdoor read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bd_rdata <= '0;
        else        bd_rdata <= mem[bd_addr];
    end
endmodule

// File: tb/tb_qspi_mem_responder.sv
// Self-checking bench for qspi_mem_responder: directed vector table, hand-written
// corner sequences and random transactions against a byte-array reference model.
module tb_qspi_mem_responder;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int SYNC  = 2;
    localparam int H     = 4;

    logic          clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sclk = 1'b0;
    logic [3:0]    io_in = '0;
    logic [3:0]    io_out, io_oe;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [7:0]    bd_wdata = '0;
    logic [7:0]    bd_rdata;
    logic          cmd_err;

    qspi_mem_responder #(.DEPTH(DEPTH), .QUAD_DUMMY(6), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .bd_we(bd_we), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int         errors = 0, checks = 0, bad_lines = 0, err_pulses = 0;
    logic [7:0] ref_mem [DEPTH];

    always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        logic [31:0] data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit is_quad(input logic [7:0] op);
        return op == 8'hEB || op == 8'h38;
    endfunction

    function automatic bit is_read(input logic [7:0] op);
        return op == 8'h03 || op == 8'hEB;
    endfunction

    // One sclk period: present data, sample device output just before the rise.
    task automatic xfer(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        io_in = d;
        tick(H);
        q  = io_out;
        oe = io_oe;
        sclk = 1'b1;
        tick(H);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int nbits);
        logic [3:0] q, oe;
        for (int i = nbits - 1; i >= 0; i--) begin
            xfer({3'b000, v[i]}, q, oe);
            if (oe !== 4'b0000) bad_lines++;
        end
    endtask

    task automatic send_nibbles(input logic [31:0] v, input int nnib);
        logic [3:0] q, oe;
        for (int i = nnib - 1; i >= 0; i--) begin
            xfer(v[4*i +: 4], q, oe);
            if (oe !== 4'b0000) bad_lines++;
        end
    endtask

    task automatic send_header(input logic [7:0] op, input logic [23:0] addr);
        send_bits({24'h0, op}, 8);
        if (is_quad(op)) send_nibbles({8'h0, addr}, 6);
        else             send_bits({8'h0, addr}, 24);
        if (op == 8'hEB) send_nibbles(32'($urandom), 6);
    endtask

    task automatic read_byte(input bit quad, output logic [7:0] b);
        logic [3:0] q, oe;
        b = '0;
        if (quad) begin
            for (int i = 0; i < 2; i++) begin
                xfer(4'h0, q, oe);
                b = {b[3:0], q};
                if (oe !== 4'b1111) bad_lines++;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                xfer(4'h0, q, oe);
                b = {b[6:0], q[1]};
                if (oe !== 4'b0010 || (q & 4'b1101) !== 4'b0000) bad_lines++;
            end
        end
    endtask

    task automatic write_byte(input bit quad, input logic [7:0] b);
        if (quad) send_nibbles({24'h0, b}, 2);
        else      send_bits({24'h0, b}, 8);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_end();
        tick(2);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic bd_write(input int a, input logic [7:0] d);
        bd_we = 1'b1;
        bd_addr = AW'(a);
        bd_wdata = d;
        tick(1);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bd_read(input int a, output logic [7:0] d);
        bd_addr = AW'(a);
        tick(1);
        d = bd_rdata;
    endtask

    // Full transaction; data holds n bytes, first byte in the most significant used position.
    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int n,
                           input logic [31:0] data);
        logic [7:0] b, got;
        int a;
        bit quad;
        quad = is_quad(op);
        bad_lines = 0;
        cs_start();
        send_header(op, addr);
        for (int k = 0; k < n; k++) begin
            a = (int'(addr[AW-1:0]) + k) % DEPTH;
            b = data[8*(n-1-k) +: 8];
            if (is_read(op)) begin
                read_byte(quad, got);
                check($sformatf("read op=%h idx=%h", op, a), {24'h0, got}, {24'h0, b});
            end else begin
                write_byte(quad, b);
                ref_mem[a] = b;
            end
        end
        if (is_read(op)) begin
            cs_n = 1'b1;
            tick(SYNC + 1);
            check($sformatf("io_oe after cs rise op=%h", op), {28'h0, io_oe}, 32'h0);
            check($sformatf("io_out after cs rise op=%h", op), {28'h0, io_out}, 32'h0);
            tick(8);
        end else begin
            cs_end();
        end
        check($sformatf("bus lines during op=%h", op), bad_lines, 0);
        if (!is_read(op)) begin
            for (int k = 0; k < n; k++) begin
                a = (int'(addr[AW-1:0]) + k) % DEPTH;
                bd_read(a, got);
                check($sformatf("written byte idx=%h", a), {24'h0, got}, {24'h0, ref_mem[a]});
            end
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [7:0]  got, first, ops[4];
        logic [3:0]  q, oe, oe_or;
        logic [31:0] data;
        logic [23:0] addr;
        logic [7:0]  op;
        int          n, e0;

        vecs[0] = '{8'h03, 24'h000010, 4, 32'hA55AC33C};
        vecs[1] = '{8'h02, 24'h000020, 2, 32'h00001122};
        vecs[2] = '{8'hEB, 24'h000010, 2, 32'h0000A55A};
        vecs[3] = '{8'h38, 24'h0003FF, 2, 32'h00007788};
        vecs[4] = '{8'h03, 24'h0003FF, 2, 32'h00007788};
        vecs[5] = '{8'hEB, 24'hC00020, 2, 32'h00001122};
        ops[0] = 8'h03; ops[1] = 8'h02; ops[2] = 8'hEB; ops[3] = 8'h38;

        // Reset values
        tick(3);
        check("reset io_out", {28'h0, io_out}, 32'h0);
        check("reset io_oe", {28'h0, io_oe}, 32'h0);
        check("reset cmd_err", {31'h0, cmd_err}, 32'h0);
        check("reset bd_rdata", {24'h0, bd_rdata}, 32'h0);
        rst_n = 1'b1;
        tick(4);

        for (int a = 0; a < DEPTH; a++) bd_write(a, 8'($urandom));
        bd_write(16'h10, 8'hA5);
        bd_write(16'h11, 8'h5A);
        bd_write(16'h12, 8'hC3);
        bd_write(16'h13, 8'h3C);
        bd_read(16'h12, got);
        check("backdoor readback", {24'h0, got}, 32'hC3);

        // Directed vector table
        for (int v = 0; v < 6; v++) run_txn(vecs[v].op, vecs[v].addr, vecs[v].n, vecs[v].data);
        bd_read(16'h000, got);
        check("wrap write mem[0]", {24'h0, got}, 32'h88);
        bd_read(16'h3FF, got);
        check("wrap write mem[3FF]", {24'h0, got}, 32'h77);

        // Partial write: 12 bits, only the first byte lands
        first = 8'h6B;
        bad_lines = 0;
        cs_start();
        send_header(8'h02, 24'h000030);
        write_byte(1'b0, first);
        send_bits(32'hF, 4);
        cs_end();
        ref_mem[16'h30] = first;
        bd_read(16'h30, got);
        check("partial write mem[30]", {24'h0, got}, {24'h0, ref_mem[16'h30]});
        bd_read(16'h31, got);
        check("partial write mem[31]", {24'h0, got}, {24'h0, ref_mem[16'h31]});

        // Unsupported opcode
        e0 = err_pulses;
        oe_or = '0;
        cs_start();
        send_bits(32'h9F, 8);
        for (int i = 0; i < 16; i++) begin
            xfer(4'($urandom), q, oe);
            oe_or = oe_or | oe;
        end
        cs_end();
        check("cmd_err pulses for 0x9F", err_pulses - e0, 1);
        check("io_oe during ignore", {28'h0, oe_or}, 32'h0);

        // Asynchronous reset in the middle of a single-bit read
        cs_start();
        send_header(8'h03, 24'h000010);
        xfer(4'h0, q, oe);
        xfer(4'h0, q, oe);
        tick(4);
        check("pre-reset io_out", {28'h0, io_out}, 32'h2);
        check("pre-reset io_oe", {28'h0, io_oe}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("reset mid-read io_out", {28'h0, io_out}, 32'h0);
        check("reset mid-read io_oe", {28'h0, io_oe}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        oe_or = '0;
        for (int i = 0; i < 16; i++) begin
            xfer(4'($urandom), q, oe);
            oe_or = oe_or | oe;
        end
        check("io_oe in frame after reset", {28'h0, oe_or}, 32'h0);
        cs_end();
        run_txn(8'h03, 24'h000010, 2, 32'h0000A55A);

        // Random transactions against the reference model
        for (int t = 0; t < 24; t++) begin
            op   = ops[$urandom_range(0, 3)];
            addr = 24'($urandom);
            n    = $urandom_range(1, 4);
            if (is_read(op)) begin
                data = '0;
                for (int k = 0; k < n; k++)
                    data = {data[23:0], ref_mem[(int'(addr[AW-1:0]) + k) % DEPTH]};
            end else begin
                data = $urandom;
            end
            run_txn(op, addr, n, data);
        end

        check("total cmd_err pulses", err_pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
